axi_read_responder: RTL and testbench
=====================================

# axi_read_responder

Slave-side AXI read-channel responder. It sits between one interconnect slave port (S0–S7) and a synchronous single-port SRAM macro. It accepts one AR request at a time, fetches each beat from the SRAM, and returns the burst on the R channel with the request ID echoed. It honours RREADY backpressure, supports FIXED, INCR and WRAP bursts, and reports address-decode and size errors in RRESP.

## Interface
- ID_BITS, 8: width of ARID/RID (master ID plus interconnect tag).
- ADDR_BITS, 32: AXI address width.
- DATA_BITS, 32: AXI data width; one beat is one word.
- LEN_BITS, 4: ARLEN width (1–16 beats).
- MEM_AW, 14: SRAM word-address width.
- BASE_ADDR, 32'h0001_0000: region base; the region size is 4·2^MEM_AW bytes.

Ports:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- ARID  in  ID_BITS  request ID.
- ARADDR  in  ADDR_BITS  byte start address.
- ARLEN  in  LEN_BITS  beats minus one.
- ARSIZE  in  3  beat size.
- ARBURST  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
- ARVALID  in  1  request valid.
- ARREADY  out  1  request accepted.
- RID  out  ID_BITS  echoed ID.
- RDATA  out  DATA_BITS  beat data.
- RRESP  out  2  response: 0 OKAY, 2 SLVERR, 3 DECERR.
- RLAST  out  1  final beat.
- RVALID  out  1  beat valid.
- RREADY  in  1  master accepts beat.
- mem_cs  out  1  SRAM read strobe.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_rdata  in  DATA_BITS  SRAM output; valid the cycle after the edge that sampled mem_cs.

## Operation
- The FSM has four states: IDLE, FETCH, WAIT, DATA.
- IDLE
  - ARREADY=1.
  - On ARVALID&&ARREADY, register ARID, ARADDR, ARLEN, ARBURST, clear beat_cnt, compute the error code, then go to FETCH.
- FETCH
  - mem_cs=1 unless the burst is in error.
  - mem_addr=cur_addr[MEM_AW+1:2].
  - Next state is WAIT.
- WAIT
  - rdata_q<=mem_rdata, or 0 if the burst is in error.
  - Next state is DATA.
- DATA
  - RVALID=1, RDATA=rdata_q, RID=captured ID, RRESP=error code.
  - RLAST=(beat_cnt==len_q).
  - On RREADY: if RLAST, go to IDLE; otherwise beat_cnt+1, advance cur_addr, go to FETCH.
  - Without RREADY: stay in DATA with all R outputs stable.
- Error code is latched at AR acceptance and applies to every beat of the burst.
  - DECERR: ARADDR[ADDR_BITS-1:MEM_AW+2] differs from BASE_ADDR[ADDR_BITS-1:MEM_AW+2].
  - Else SLVERR: ARSIZE != 3'b010, or ARBURST==3, or WRAP with ARLEN not in {1,3,7,15}.
  - Else OKAY.
- Error bursts still produce exactly ARLEN+1 beats, with identical state timing, RDATA=0 and mem_cs never asserted.
- Address advance, always in bytes, low two bits ignored:
  - FIXED: unchanged.
  - INCR: cur_addr+4, wrapping modulo the SRAM word space at the top of the region with no error.
  - WRAP: mask=(len_q+1)*4-1; next=(cur_addr & ~mask) | ((cur_addr+4) & mask).
- Only one outstanding burst; ARREADY is low for the whole burst.

## Timing
- Reset values (while ARESETn low and immediately after):
  - State IDLE, ARREADY=1.
  - RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0.
  - mem_cs=0, mem_addr=0, beat_cnt=0.
- ARREADY, RVALID, RLAST and mem_cs decode from registered state only; no combinational path from any input to any output.
- AR handshake at edge E0: FETCH in cycle E0..E1, WAIT in E1..E2, RVALID first high after E2. Latency from handshake to first beat is 3 cycles.
- Beat cadence with RREADY held high is 3 cycles per beat; a 16-beat burst occupies 48 cycles from AR handshake to the final R handshake.
- RREADY low for N cycles in DATA extends that beat by N cycles. RDATA, RID, RRESP and RLAST must not change during the stall.
- ARVALID asserted during a burst is ignored until the IDLE cycle after the RLAST handshake. The earliest next acceptance is the cycle after the last R handshake.
- Asynchronous reset mid-burst forces IDLE and the reset values immediately. The burst is abandoned and no further beats are issued.

## Test plan
- INCR single: ARADDR=0x0001_0010, ARLEN=0, ARID=0x12, SRAM word 4 = 0xDEADBEEF → 3 cycles later one beat: RDATA=0xDEADBEEF, RLAST=1, RRESP=0, RID=0x12; ARREADY high again the next cycle.
- INCR 4-beat with backpressure: ARADDR=0x0001_0000, ARLEN=3, RREADY low 5 cycles on beat 2 → mem_addr sequence 0,1,2,3; beat 2 RDATA stable during the stall; RLAST only on beat 4; total 12+5 cycles.
- WRAP: ARADDR=0x0001_0008, ARLEN=3 → word addresses 2,3,0,1. ARLEN=2 with WRAP → 3 beats of RRESP=2, RDATA=0, mem_cs never asserted.
- DECERR: ARADDR=0x0002_0000, ARLEN=1 → 2 beats with RRESP=3, RDATA=0, mem_cs=0 throughout.
- FIXED plus size error: FIXED with ARLEN=2 at word 5 reads word 5 three times. ARSIZE=3'b001 gives RRESP=2 on every beat.
- Reset mid-burst: assert ARESETn low during beat 3 of an ARLEN=7 burst → RVALID=0 and ARREADY=1 asynchronously; after release a new ARLEN=0 request completes normally.

Source files
------------

// File: rtl/axi_read_responder_if.sv
// AXI read-address and read-data channels between one interconnect slave port and the SRAM responder.
interface axi_read_responder_if #(
  parameter int unsigned ID_BITS   = 8,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LEN_BITS  = 4
);
  logic [ID_BITS-1:0]   ARID;
  logic [ADDR_BITS-1:0] ARADDR;
  logic [LEN_BITS-1:0]  ARLEN;
  logic [2:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [ID_BITS-1:0]   RID;
  logic [DATA_BITS-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_read_responder.sv
// Single-outstanding AXI read responder: fetches each beat from a 1-cycle-latency SRAM and
// returns FIXED/INCR/WRAP bursts with the request ID echoed and errors reported in RRESP.
module axi_read_responder #(
  parameter int unsigned          ID_BITS   = 8,
  parameter int unsigned          ADDR_BITS = 32,
  parameter int unsigned          DATA_BITS = 32,
  parameter int unsigned          LEN_BITS  = 4,
  parameter int unsigned          MEM_AW    = 14,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = ADDR_BITS'(32'h0001_0000)
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_read_responder_if.slave  axi,
  output logic                 mem_cs,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam int unsigned TAG_LSB     = MEM_AW + 2;
  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;
  localparam logic [1:0]  RESP_DECERR = 2'd3;
  localparam logic [1:0]  BURST_FIXED = 2'd0;
  localparam logic [1:0]  BURST_WRAP  = 2'd2;
  localparam logic [1:0]  BURST_RSVD  = 2'd3;
  localparam logic [2:0]  SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_DATA} state_t;

  state_t               state;
  logic                 arready;
  logic                 rvalid;
  logic                 rlast;
  logic [ID_BITS-1:0]   rid;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic [LEN_BITS-1:0]  len_q;
  logic [LEN_BITS-1:0]  beat_cnt;
  logic [1:0]           burst_q;
  logic [MEM_AW-1:0]    cur_addr;

  logic [LEN_BITS-1:0]  len_inc_c;
  logic                 wrap_len_ok_c;
  logic [1:0]           ar_err_c;
  logic [MEM_AW-1:0]    wrap_mask_c;
  logic [MEM_AW-1:0]    addr_inc_c;
  logic [MEM_AW-1:0]    next_addr_c;
  logic                 burst_ok_c;

  assign axi.ARREADY = arready;
  assign axi.RVALID  = rvalid;
  assign axi.RLAST   = rlast;
  assign axi.RID     = rid;
  assign axi.RDATA   = rdata;
  assign axi.RRESP   = rresp;
  assign mem_addr    = cur_addr;

  // rresp holds the code latched at acceptance for the whole burst
  assign burst_ok_c = (rresp == RESP_OKAY);

  // Request classification: a WRAP length must be a power of two of at least 2 beats.
  always_comb begin
    len_inc_c     = axi.ARLEN + LEN_BITS'(1);
    wrap_len_ok_c = (axi.ARLEN != '0) && ((axi.ARLEN & len_inc_c) == '0);
    ar_err_c      = RESP_OKAY;
    if (axi.ARADDR[ADDR_BITS-1:TAG_LSB] != BASE_ADDR[ADDR_BITS-1:TAG_LSB]) begin
      ar_err_c = RESP_DECERR;
    end else if ((axi.ARSIZE != SIZE_WORD) || (axi.ARBURST == BURST_RSVD) ||
                 ((axi.ARBURST == BURST_WRAP) && !wrap_len_ok_c)) begin
      ar_err_c = RESP_SLVERR;
    end
  end

  // Word-address advance; the WRAP word mask equals len_q for the legal WRAP lengths.
  always_comb begin
    addr_inc_c  = cur_addr + MEM_AW'(1);
    wrap_mask_c = MEM_AW'(len_q);
    case (burst_q)
      BURST_FIXED: next_addr_c = cur_addr;
      BURST_WRAP:  next_addr_c = (cur_addr & ~wrap_mask_c) | (addr_inc_c & wrap_mask_c);
      default:     next_addr_c = addr_inc_c;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= ST_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      len_q    <= '0;
      beat_cnt <= '0;
      burst_q  <= '0;
      cur_addr <= '0;
      mem_cs   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (axi.ARVALID) begin
            rid      <= axi.ARID;
            len_q    <= axi.ARLEN;
            burst_q  <= axi.ARBURST;
            rresp    <= ar_err_c;
            beat_cnt <= '0;
            cur_addr <= MEM_AW'(axi.ARADDR[TAG_LSB-1:0] >> 2);
            mem_cs   <= (ar_err_c == RESP_OKAY);
            arready  <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          mem_cs <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          rdata  <= burst_ok_c ? mem_rdata : '0;
          rlast  <= (beat_cnt == len_q);
          rvalid <= 1'b1;
          state  <= ST_DATA;
        end
        ST_DATA: begin
          // all R outputs hold while RREADY is low
          if (axi.RREADY) begin
            rvalid <= 1'b0;
            if (rlast) begin
              rlast   <= 1'b0;
              arready <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + LEN_BITS'(1);
              cur_addr <= next_addr_c;
              mem_cs   <= burst_ok_c;
              state    <= ST_FETCH;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: table of directed bursts, multi-cycle corner sequences and
// random bursts checked against a burst-level reference model and an SRAM model.
module tb_axi_read_responder;

  localparam int MEM_WORDS = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_cs;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;

  axi_read_responder_if bus ();

  axi_read_responder dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .axi       (bus),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic [13:0] cs_log[$];
  always @(posedge clk) begin
    if (mem_cs) begin
      mem_rdata <= mem[mem_addr];
      cs_log.push_back(mem_addr);
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          stall_beat;
    int          stall_n;
    logic [1:0]  exp_resp;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (addr[31:16] != 16'h0001) return 2'd3;
    if (size != 3'd2 || burst == 2'd3) return 2'd2;
    if (burst == 2'd2 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int model_word(input logic [31:0] addr, input int len,
                                    input logic [1:0] burst, input int k);
    int w0 = int'(addr[15:2]);
    int n  = len + 1;
    case (burst)
      2'd0:    return w0;
      2'd2:    return (w0 / n) * n + ((w0 % n + k) % n);
      default: return (w0 + k) % MEM_WORDS;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge right after the final R handshake.
  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_beat, input int stall_n, input bit rand_bp,
                           input bit junk_ar, input logic [1:0] exp_resp, input int exp_cycles);
    int n, c0, prev, hs, stall_k, stalls, guard, nbeats;
    bit got, rr;
    logic [31:0] exp_data;
    nbeats = int'(len) + 1;
    cs_log.delete();
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    n = 0;
    while (bus.ARREADY !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ARREADY !== 1'b1) begin
      check("ar_accept_timeout", 64'(bus.ARREADY), 64'd1);
      bus.ARVALID = 1'b0;
      return;
    end
    @(negedge clk);
    c0 = cyc;
    if (junk_ar) begin
      bus.ARID   = ~id;
      bus.ARADDR = $urandom;
      bus.ARLEN  = 4'($urandom);
    end else begin
      bus.ARVALID = 1'b0;
    end
    prev   = c0;
    stalls = 0;
    for (int k = 0; k < nbeats; k++) begin
      stall_k  = 0;
      got      = 1'b0;
      guard    = 0;
      exp_data = (exp_resp == 2'd0) ? mem[model_word(addr, int'(len), burst, k)] : 32'h0;
      while (!got && guard < 200) begin
        check("arready_busy", 64'(bus.ARREADY), 64'd0);
        if (bus.RVALID) begin
          check("rdata", 64'(bus.RDATA), 64'(exp_data));
          check("rid", 64'(bus.RID), 64'(id));
          check("rresp", 64'(bus.RRESP), 64'(exp_resp));
          check("rlast", 64'(bus.RLAST), 64'(k == nbeats - 1));
          if (k == stall_beat && stall_k < stall_n) rr = 1'b0;
          else if (rand_bp) rr = ($urandom_range(3) != 0);
          else rr = 1'b1;
          bus.RREADY = rr;
          if (rr) begin
            got = 1'b1;
            hs  = cyc + 1;
            check("beat_gap", 64'(hs - prev), 64'(3 + stall_k));
            prev       = hs;
            last_rdata = bus.RDATA;
          end else begin
            stall_k++;
            stalls++;
          end
        end else begin
          bus.RREADY = rand_bp ? 1'($urandom_range(1)) : 1'b0;
        end
        @(negedge clk);
        guard++;
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout beat=%0d of %0d never handshaked", k, nbeats);
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;
        return;
      end
    end
    bus.RREADY  = 1'b0;
    bus.ARVALID = 1'b0;
    check("arready_after", 64'(bus.ARREADY), 64'd1);
    check("rvalid_after", 64'(bus.RVALID), 64'd0);
    check("burst_cycles", 64'(prev - c0), 64'((exp_cycles >= 0) ? exp_cycles : 3 * nbeats + stalls));
    if (exp_resp != 2'd0) begin
      check("cs_count_err", 64'(cs_log.size()), 64'd0);
    end else begin
      check("cs_count", 64'(cs_log.size()), 64'(nbeats));
      for (int k = 0; k < cs_log.size() && k < nbeats; k++)
        check("cs_addr", 64'(cs_log[k]), 64'(model_word(addr, int'(len), burst, k)));
    end
  endtask

  initial begin
    int n, hs, guard;
    bit done;
    logic [7:0]  r_id;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;

    vecs[0] = '{8'h12, 32'h0001_0010, 4'd0,  3'd2, 2'd1, -1, 0, 2'd0, 3};
    vecs[1] = '{8'h34, 32'h0001_0000, 4'd3,  3'd2, 2'd1,  1, 5, 2'd0, 17};
    vecs[2] = '{8'h56, 32'h0001_0008, 4'd3,  3'd2, 2'd2, -1, 0, 2'd0, 12};
    vecs[3] = '{8'h57, 32'h0001_0008, 4'd2,  3'd2, 2'd2, -1, 0, 2'd2, 9};
    vecs[4] = '{8'h78, 32'h0002_0000, 4'd1,  3'd2, 2'd1, -1, 0, 2'd3, 6};
    vecs[5] = '{8'h9a, 32'h0001_0014, 4'd2,  3'd2, 2'd0, -1, 0, 2'd0, 9};
    vecs[6] = '{8'h9b, 32'h0001_0014, 4'd2,  3'd1, 2'd0, -1, 0, 2'd2, 9};
    vecs[7] = '{8'hc1, 32'h0001_fff8, 4'd15, 3'd2, 2'd1, -1, 0, 2'd0, 48};
    vecs[8] = '{8'hc2, 32'h0001_0100, 4'd1,  3'd2, 2'd3, -1, 0, 2'd2, 6};
    vecs[9] = '{8'hc3, 32'h0001_0024, 4'd15, 3'd2, 2'd2,  2, 4, 2'd0, 52};

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;

    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
    bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    #12;
    check("rst_arready", 64'(bus.ARREADY), 64'd1);
    check("rst_rvalid", 64'(bus.RVALID), 64'd0);
    check("rst_rlast", 64'(bus.RLAST), 64'd0);
    check("rst_rdata", 64'(bus.RDATA), 64'd0);
    check("rst_rresp", 64'(bus.RRESP), 64'd0);
    check("rst_rid", 64'(bus.RID), 64'd0);
    check("rst_mem_cs", 64'(mem_cs), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, back-to-back; odd entries also hold a junk AR request during the burst
    for (int i = 0; i < 10; i++) begin
      run_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                vecs[i].stall_beat, vecs[i].stall_n, 1'b0, 1'(i % 2), vecs[i].exp_resp,
                vecs[i].exp_cycles);
      if (i == 0) check("single_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
      if (i == 1 && cs_log.size() == 4) begin
        check("incr_seq0", 64'(cs_log[0]), 64'd0);
        check("incr_seq3", 64'(cs_log[3]), 64'd3);
      end
      if (i == 2 && cs_log.size() == 4) begin
        check("wrap_seq0", 64'(cs_log[0]), 64'd2);
        check("wrap_seq1", 64'(cs_log[1]), 64'd3);
        check("wrap_seq2", 64'(cs_log[2]), 64'd0);
        check("wrap_seq3", 64'(cs_log[3]), 64'd1);
      end
      if (i == 5) begin
        foreach (cs_log[j]) check("fixed_word", 64'(cs_log[j]), 64'd5);
      end
    end

    // Asynchronous reset during beat 3 of an 8-beat burst
    bus.ARID = 8'hA5; bus.ARADDR = 32'h0001_0040; bus.ARLEN = 4'd7;
    bus.ARSIZE = 3'd2; bus.ARBURST = 2'd1; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    n = 0;
    while (bus.ARREADY !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.ARVALID = 1'b0;
    hs = 0; done = 1'b0; guard = 0;
    while (!done && guard < 100) begin
      if (bus.RVALID) begin
        if (hs == 2) begin
          #2 rst_n = 1'b0;
          #1;
          check("mid_rst_rvalid", 64'(bus.RVALID), 64'd0);
          check("mid_rst_arready", 64'(bus.ARREADY), 64'd1);
          check("mid_rst_rlast", 64'(bus.RLAST), 64'd0);
          check("mid_rst_rdata", 64'(bus.RDATA), 64'd0);
          check("mid_rst_rid", 64'(bus.RID), 64'd0);
          check("mid_rst_mem_cs", 64'(mem_cs), 64'd0);
          done = 1'b1;
        end else begin
          hs++;
        end
      end
      if (!done) @(negedge clk);
      guard++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL mid_rst_timeout beat 3 never presented, beats=%0d", hs);
    end
    bus.RREADY = 1'b0;
    @(negedge clk);
    check("rst_hold_rvalid", 64'(bus.RVALID), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_burst(8'h3C, 32'h0001_001C, 4'd0, 3'd2, 2'd1, -1, 0, 1'b0, 1'b0, 2'd0, 3);

    // Random bursts with random backpressure against the reference model
    for (int it = 0; it < 40; it++) begin
      r_id    = 8'($urandom);
      r_addr  = ($urandom_range(7) == 0) ? $urandom : {16'h0001, 16'($urandom)};
      r_len   = 4'($urandom);
      r_size  = ($urandom_range(5) == 0) ? 3'($urandom) : 3'd2;
      r_burst = 2'($urandom);
      if (r_burst == 2'd2 && $urandom_range(1) == 1)
        r_len = 4'((2 << $urandom_range(3)) - 1);
      run_burst(r_id, r_addr, r_len, r_size, r_burst, -1, 0, 1'b1, 1'($urandom_range(1)),
                model_resp(r_addr, r_len, r_size, r_burst), -1);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
